updown_sweep_ctrl: RTL and testbench
====================================

Name: updown_sweep_ctrl

Overview:
- Sequencer for the 5-bit up/down counter. Drives its load, enable and direction controls, and monitors its count output.
- Runs a programmed number of triangular sweeps between a lower and an upper limit, with an optional dwell at each limit.
- Sits between a host or register interface (start/done handshake) and the counter instance.

Parameters:
- CW, 5, counter width; limit inputs, load value and count feedback are all CW bits.
- DW, 4, width of the dwell and sweep-count fields.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in any non-IDLE state.
- lo_limit  in  CW  lower sweep bound; latched on an accepted start.
- hi_limit  in  CW  upper sweep bound; latched on an accepted start.
- dwell  in  DW  hold cycles at each limit (0 = no dwell); latched on an accepted start.
- sweeps  in  DW  number of full lo→hi→lo sweeps; latched on an accepted start.
- count  in  CW  feedback from the counter.
- cnt_load  out  1  counter loads cnt_load_val at the next edge.
- cnt_load_val  out  CW  load value, always equal to the latched lo_limit.
- cnt_enable  out  1  counter steps at the next edge.
- cnt_dir  out  1  1 = up, 0 = down.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  qualifies done: the start was rejected.
- sweep_cnt  out  DW  number of completed sweeps.

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0. Config registers 0.
- Counter contract: cnt_load has priority over cnt_enable. The count updates one edge after either is asserted.
- States: IDLE, LOAD, UP, DWELL_HI, DOWN, DWELL_LO, FIN.
- IDLE, start=1, config valid (lo_limit < hi_limit and sweeps ≠ 0): latch the config, clear sweep_cnt, go to LOAD.
- IDLE, start=1, config invalid: go to FIN with err set. No counter activity.
- LOAD: cnt_load=1 for exactly one cycle, then go to UP.
- UP: cnt_dir=1. cnt_enable = (count ≠ hi_q), decoded combinationally from count.
  - When count == hi_q, go to DWELL_HI if dwell_q ≠ 0, otherwise directly to DOWN.
- DWELL_HI: cnt_enable=0. Hold for exactly dwell_q cycles, then go to DOWN.
- DOWN: cnt_dir=0. cnt_enable = (count ≠ lo_q).
  - When count == lo_q, increment sweep_cnt and go to DWELL_LO, or skip it if dwell_q = 0.
- Exit from DWELL_LO (or from DOWN when dwell_q = 0):
  - If sweep_cnt == sweeps_q, go to FIN.
  - Otherwise go to UP.
- FIN: done=1 for one cycle. err stays valid during that cycle. Return to IDLE.
- Abort: from any non-IDLE state, next state is IDLE.
  - cnt_enable and cnt_load are 0 in the abort cycle.
  - No done pulse. sweep_cnt holds its value.
- start while busy is ignored. abort has priority over every transition in the same cycle.
- cnt_dir holds its last value in dwell, FIN and IDLE, so the counter direction does not glitch.
- Latency: with dwell=0, one sweep takes 1 + 2·(hi−lo) + 2 cycles from LOAD to FIN.
- Limits use unsigned compare. lo=0 and hi=31 are legal; the counter never wraps under control.

Optional Feature:
- Macro: UPDOWN_SWEEP_PAUSE_EN.
- When defined:
  - Adds input pause (1 bit).
  - While pause=1 in UP, DOWN or a dwell state: cnt_enable=0, the dwell timer freezes and the state holds.
  - Releasing pause resumes exactly where it stopped.
  - abort still wins over pause.
- When undefined: the port is absent and the logic is identical to tying pause to 0.

Decomposition:
- Package updown_sweep_pkg:
  - Enumerated state type (3-bit encoding).
  - CW and DW defaults.
  - Direction constants DIR_UP=1 and DIR_DOWN=0.
- Sub-module updown_dwell_timer: loadable DW-bit down-counter.
  - Inputs: clk, reset, load, load_val, hold.
  - Output: expired.
  - Reused for both dwell states.
- The top-level instantiates the timer plus the FSM. The counter itself is instantiated by the integrating level, not inside this block.

Test Plan:
- lo=2, hi=5, dwell=0, sweeps=1, with a behavioural counter: count sequence 2,3,4,5,4,3,2. Then done=1, err=0, sweep_cnt=1, busy falls one cycle after done.
- lo=0, hi=3, dwell=2, sweeps=2: two consecutive enable-low cycles at count=3 and at count=0 in each sweep. sweep_cnt steps 1→2. done after the second sweep only.
- lo=7, hi=7 (and separately sweeps=0): done=1 and err=1 two cycles after start. cnt_load and cnt_enable never assert.
- abort asserted at count=4 while going up (lo=1, hi=9): enable drops the same cycle, state returns to IDLE, no done, count frozen at 4 or 5.
- start pulsed again while busy, plus reset asserted mid-DOWN: the second start has no effect. Reset forces all outputs to 0 asynchronously, and a fresh start then runs normally.
- (PAUSE_EN) pause held for 5 cycles during DWELL_HI with dwell=3: total hold is 8 cycles, then DOWN resumes.

Source files
------------

// File: rtl/updown_sweep_pkg.sv
// ============================================================================
// Module      : updown_sweep_pkg
// Description : Shared types and constants for the up/down sweep sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package updown_sweep_pkg;

    localparam int CW_DEF = 5;
    localparam int DW_DEF = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_UP       = 3'd2,
        S_DWELL_HI = 3'd3,
        S_DOWN     = 3'd4,
        S_DWELL_LO = 3'd5,
        S_FIN      = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/updown_dwell_timer.sv
// ============================================================================
// Module      : updown_dwell_timer
// Description : Loadable down-counter timing the dwell at either sweep limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_dwell_timer #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          hold,
    output logic          expired
);

    localparam logic [DW-1:0] c_one = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (!hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    // Loaded with N on entry, so a count of one marks the last of N cycles.
    assign expired = !hold && (r_cnt == c_one);

endmodule

`default_nettype wire

// File: rtl/updown_sweep_ctrl.sv
// ============================================================================
// Module      : updown_sweep_ctrl
// Description : Runs triangular lo->hi->lo sweeps on an external up/down
//               counter. Optional pause input under UPDOWN_SWEEP_PAUSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
`ifdef UPDOWN_SWEEP_PAUSE_EN
    input  logic          pause,
`endif
    input  logic [CW-1:0] lo_limit,
    input  logic [CW-1:0] hi_limit,
    input  logic [DW-1:0] dwell,
    input  logic [DW-1:0] sweeps,
    input  logic [CW-1:0] count,
    output logic          cnt_load,
    output logic [CW-1:0] cnt_load_val,
    output logic          cnt_enable,
    output logic          cnt_dir,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] sweep_cnt
);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_lo;
    logic [CW-1:0] r_hi;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] r_sweeps;
    logic [DW-1:0] r_sweep_cnt;
    logic          r_err;
    logic          r_dir;

    logic          w_pause;
    logic          w_cfg_ok;
    logic          w_latch;
    logic          w_reject;
    logic          w_inc;
    logic          w_tmr_load;
    logic          w_expired;
    logic [DW-1:0] w_sweep_next;

`ifdef UPDOWN_SWEEP_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_cfg_ok     = (lo_limit < hi_limit) && (sweeps != '0);
    assign w_sweep_next = r_sweep_cnt + {{(DW-1){1'b0}}, 1'b1};

    updown_dwell_timer #(
        .DW (DW)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tmr_load),
        .load_val (r_dwell),
        .hold     (w_pause),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lo        <= '0;
            r_hi        <= '0;
            r_dwell     <= '0;
            r_sweeps    <= '0;
            r_sweep_cnt <= '0;
            r_err       <= 1'b0;
            r_dir       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_dir   <= cnt_dir;
            if (w_latch) begin
                r_lo        <= lo_limit;
                r_hi        <= hi_limit;
                r_dwell     <= dwell;
                r_sweeps    <= sweeps;
                r_sweep_cnt <= '0;
                r_err       <= 1'b0;
            end else if (w_reject) begin
                r_err <= 1'b1;
            end else if (w_inc) begin
                r_sweep_cnt <= w_sweep_next;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        cnt_load     = 1'b0;
        cnt_enable   = 1'b0;
        done         = 1'b0;
        w_latch      = 1'b0;
        w_reject     = 1'b0;
        w_inc        = 1'b0;
        w_tmr_load   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_latch      = 1'b1;
                        w_next_state = S_LOAD;
                    end else begin
                        w_reject     = 1'b1;
                        w_next_state = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                cnt_load     = 1'b1;
                w_next_state = S_UP;
            end
            S_UP: begin
                if (!w_pause) begin
                    if (count != r_hi) begin
                        cnt_enable = 1'b1;
                    end else if (r_dwell != '0) begin
                        w_tmr_load   = 1'b1;
                        w_next_state = S_DWELL_HI;
                    end else begin
                        w_next_state = S_DOWN;
                    end
                end
            end
            S_DWELL_HI: begin
                if (w_expired) begin
                    w_next_state = S_DOWN;
                end
            end
            S_DOWN: begin
                if (!w_pause) begin
                    if (count != r_lo) begin
                        cnt_enable = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                        if (r_dwell != '0) begin
                            w_tmr_load   = 1'b1;
                            w_next_state = S_DWELL_LO;
                        end else if (w_sweep_next == r_sweeps) begin
                            w_next_state = S_FIN;
                        end else begin
                            w_next_state = S_UP;
                        end
                    end
                end
            end
            S_DWELL_LO: begin
                // The sweep was already counted on arrival at lo.
                if (w_expired) begin
                    w_next_state = (r_sweep_cnt == r_sweeps) ? S_FIN : S_UP;
                end
            end
            S_FIN: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
            cnt_load     = 1'b0;
            cnt_enable   = 1'b0;
            done         = 1'b0;
            w_inc        = 1'b0;
            w_tmr_load   = 1'b0;
        end
    end

    // Direction is only driven while stepping; elsewhere it holds so the
    // counter never sees a spurious flip.
    assign cnt_dir      = (r_state == S_UP)   ? DIR_UP   :
                          (r_state == S_DOWN) ? DIR_DOWN : r_dir;
    assign cnt_load_val = r_lo;
    assign busy         = (r_state != S_IDLE);
    assign err          = done && r_err;
    assign sweep_cnt    = r_sweep_cnt;

endmodule

`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
// ============================================================================
// Module      : tb_updown_sweep_ctrl
// Description : Directed bench for updown_sweep_ctrl with a behavioural counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_sweep_ctrl;

    localparam int CW = 5;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
`ifdef UPDOWN_SWEEP_PAUSE_EN
    logic          pause = 1'b0;
`endif
    logic [CW-1:0] lo_limit = '0;
    logic [CW-1:0] hi_limit = '0;
    logic [DW-1:0] dwell = '0;
    logic [DW-1:0] sweeps = '0;
    logic [CW-1:0] count;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_enable;
    logic          cnt_dir;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] sweep_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_sweep_ctrl #(
        .CW (CW),
        .DW (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
`ifdef UPDOWN_SWEEP_PAUSE_EN
        .pause        (pause),
`endif
        .lo_limit     (lo_limit),
        .hi_limit     (hi_limit),
        .dwell        (dwell),
        .sweeps       (sweeps),
        .count        (count),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_enable   (cnt_enable),
        .cnt_dir      (cnt_dir),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .sweep_cnt    (sweep_cnt)
    );

    // Behavioural 5-bit up/down counter: load beats enable.
    always @(posedge clk or posedge reset) begin
        if (reset)           count <= '0;
        else if (cnt_load)   count <= cnt_load_val;
        else if (cnt_enable) count <= cnt_dir ? count + 5'd1 : count - 5'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a config with a one-cycle start; returns at the first sample after it.
    task automatic go(input int lo, input int hi, input int dw, input int sw);
        lo_limit = CW'(lo);
        hi_limit = CW'(hi);
        dwell    = DW'(dw);
        sweeps   = DW'(sw);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            exp1_cnt [8] = '{2, 3, 4, 5, 5, 4, 3, 2};
        logic [7:0]    en8, dir8;
        logic [25:0]   en26, dn26;
`ifdef UPDOWN_SWEEP_PAUSE_EN
        int            hold;
`endif

        // ---------------- reset ----------------
        #1 reset = 1'b1;
        #2;
        chk("rst_ctl", {busy, cnt_load, cnt_enable, cnt_dir, done, err}, 6'b0);
        chk("rst_val", {cnt_load_val, sweep_cnt}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- lo=2 hi=5 dwell=0 sweeps=1 ----------------
        go(2, 5, 0, 1);
        chk("t1_load", cnt_load, 1);
        chk("t1_ldval", cnt_load_val, 2);
        chk("t1_busy", busy, 1);
        en8 = '0; dir8 = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_count", count, exp1_cnt[i]);
            en8[i]  = cnt_enable;
            dir8[i] = cnt_dir;
        end
        chk("t1_en_seq", en8, 8'h77);
        chk("t1_dir_seq", dir8, 8'h0F);
        @(negedge clk);
        chk("t1_done", {done, err, busy}, 3'b101);
        chk("t1_sweeps", sweep_cnt, 1);
        @(negedge clk);
        chk("t1_idle", {done, busy}, 2'b00);

        // ---------------- lo=0 hi=3 dwell=2 sweeps=2 ----------------
        go(0, 3, 2, 2);
        en26 = '0; dn26 = '0;
        for (int c = 0; c < 26; c++) begin
            if (c != 0) @(negedge clk);
            en26[c] = cnt_enable;
            dn26[c] = done;
            if (c == 4)  chk("t2_at_hi", count, 3);
            if (c == 10) chk("t2_sc_pre", sweep_cnt, 0);
            if (c == 11) chk("t2_sc_1", sweep_cnt, 1);
            if (c == 12) chk("t2_at_lo", count, 0);
            if (c == 22) chk("t2_sc_1b", sweep_cnt, 1);
            if (c == 23) chk("t2_sc_2", sweep_cnt, 2);
            if (c == 25) chk("t2_err", err, 0);
        end
        // Each limit: one arrival cycle plus two dwell cycles with enable low.
        chk("t2_en_seq", en26, 26'h038E38E);
        chk("t2_done_seq", dn26, 26'h2000000);
        @(negedge clk);
        chk("t2_idle", busy, 0);

        // ---------------- rejected configs ----------------
        go(7, 7, 0, 1);
        chk("t3_rej", {done, err, busy}, 3'b111);
        chk("t3_noact", {cnt_load, cnt_enable}, 2'b00);
        @(negedge clk);
        chk("t3_idle", {done, err, busy, cnt_load, cnt_enable}, 5'b0);
        go(1, 4, 0, 0);
        chk("t3_sw0", {done, err, cnt_load, cnt_enable}, 4'b1100);
        @(negedge clk);
        chk("t3_sw0_idle", busy, 0);

        // ---------------- abort while going up ----------------
        go(1, 9, 0, 1);
        repeat (4) @(negedge clk);
        chk("t4_at4", count, 4);
        abort = 1'b1;
        #1;
        chk("t4_abort_cyc", {cnt_enable, cnt_load, done, busy}, 4'b0001);
        @(negedge clk);
        abort = 1'b0;
        chk("t4_idle", {busy, done}, 2'b00);
        chk("t4_frozen", count, 4);
        @(negedge clk);
        chk("t4_hold", {count, sweep_cnt, cnt_dir}, {5'd4, 4'd0, 1'b1});

        // ---------------- start while busy, then reset mid-DOWN ----------------
        go(2, 5, 0, 1);
        repeat (2) @(negedge clk);
        lo_limit = 5'd0; hi_limit = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_ignore", {count, cnt_load_val, cnt_load}, {5'd4, 5'd2, 1'b0});
        repeat (3) @(negedge clk);
        chk("t5_down", {count, cnt_dir, cnt_enable}, {5'd4, 1'b0, 1'b1});
        reset = 1'b1;
        #1;
        chk("t5_rst", {busy, cnt_load, cnt_enable, cnt_dir, done, err, cnt_load_val, sweep_cnt}, 0);
        @(negedge clk);
        reset = 1'b0;
        go(1, 2, 0, 1);
        chk("t5_reload", {cnt_load, cnt_load_val}, {1'b1, 5'd1});
        @(negedge clk);
        chk("t5_first", count, 1);
        repeat (4) @(negedge clk);
        chk("t5_done", {done, err, sweep_cnt}, {1'b1, 1'b0, 4'd1});

`ifdef UPDOWN_SWEEP_PAUSE_EN
        // ---------------- pause during DWELL_HI ----------------
        @(negedge clk);
        go(0, 2, 3, 1);
        repeat (3) @(negedge clk);
        chk("t6_at_hi", {count, cnt_enable}, {5'd2, 1'b0});
        hold = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            pause = (k < 5);
            #1;
            if (cnt_enable) break;
            hold++;
        end
        chk("t6_hold", hold, 8);
        chk("t6_resume", {cnt_dir, count}, {1'b0, 5'd2});
        repeat (6) @(negedge clk);
        chk("t6_done", {done, sweep_cnt}, {1'b1, 4'd1});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
